// File: rtl/spmv_row_engine.sv
// CSR sparse-matrix x dense-vector row engine: maps streamed (A, x) pairs to rows via a
// latched row_ptr table and accumulates signed products into saturating per-row accumulators.

module spmv_acc_row #(
    parameter int ACC_W = 32,
    parameter int PW    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    clr,
    input  logic                    upd,
    input  logic signed [PW-1:0]    prod,
    output logic signed [ACC_W-1:0] acc,
    output logic                    ovf
);
    localparam int SW = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [SW-1:0]    sum;
    logic signed [ACC_W-1:0] sat;
    logic                    over;

    // One extra bit of headroom: the top two bits disagree exactly when the add left range.
    always_comb begin
        sum  = SW'(acc) + SW'(prod);
        over = sum[ACC_W] ^ sum[ACC_W-1];
        sat  = sum[ACC_W-1:0];
        if (over) sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (upd) begin
            acc <= sat;
            if (over) ovf <= 1'b1;
        end
    end
endmodule

module spmv_row_engine #(
    parameter int N_ROWS = 16,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int PTR_W  = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_start,
    input  logic [(N_ROWS+1)*PTR_W-1:0]  i_row_ptr,
    input  logic                         i_nnz_valid,
    output logic                         o_nnz_ready,
    input  logic [DATA_W-1:0]            i_val_a,
    input  logic [DATA_W-1:0]            i_val_x,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [N_ROWS*ACC_W-1:0]      o_result,
    output logic [N_ROWS-1:0]            o_ovf
);
    localparam int PW = 2 * DATA_W;
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        state, state_nxt;
    logic [N_ROWS:0][PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]              k, k_inc;
    logic [1:0]                    dcnt;
    logic [RW-1:0]                 row;
    logic                          start_go, accept;
    logic                          s1_vld;
    logic signed [PW-1:0]          s1_prod;
    logic [RW-1:0]                 s1_tag;

    assign o_nnz_ready = (state == RUN);
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign start_go    = (state == IDLE) && i_start;
    assign accept      = i_nnz_valid && o_nnz_ready;
    assign k_inc       = k + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_start)
                       state_nxt = (i_row_ptr[N_ROWS*PTR_W +: PTR_W] != '0) ? RUN : DRAIN;
            RUN:   if (accept && (k_inc == ptr[N_ROWS])) state_nxt = DRAIN;
            DRAIN: if (dcnt == 2'd2) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Last row whose start index is <= k; empty rows share a start with their successor
    // and are skipped by the priority order without costing a cycle.
    always_comb begin
        row = '0;
        for (int r = 0; r < N_ROWS; r++)
            if (ptr[r] <= k) row = RW'(r);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= IDLE;
            ptr     <= '0;
            k       <= '0;
            dcnt    <= '0;
            s1_vld  <= 1'b0;
            s1_prod <= '0;
            s1_tag  <= '0;
        end else begin
            state  <= state_nxt;
            dcnt   <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
            s1_vld <= accept;
            if (start_go) begin
                ptr <= i_row_ptr;
                k   <= '0;
            end else if (accept) begin
                k <= k_inc;
            end
            if (accept) begin
                s1_prod <= PW'($signed(i_val_a)) * PW'($signed(i_val_x));
                s1_tag  <= row;
            end
        end
    end

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        spmv_acc_row #(.ACC_W(ACC_W), .PW(PW)) u_acc (
            .i_clk  (i_clk),
            .i_rstn (i_rstn),
            .clr    (start_go),
            .upd    (s1_vld && (s1_tag == RW'(r))),
            .prod   (s1_prod),
            .acc    (o_result[r*ACC_W +: ACC_W]),
            .ovf    (o_ovf[r])
        );
    end
endmodule

// File: tb/tb_spmv_row_engine.sv
// Randomized bench for spmv_row_engine: CSR jobs are replayed through a row-by-row
// reference model with saturating arithmetic, and handshake/latency behaviour is checked.

module tb_spmv_row_engine;
    localparam int N      = 16;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int PTR_W  = 8;
    localparam longint AMAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC_W-1));

    logic                      i_clk = 1'b0;
    logic                      i_rstn = 1'b0;
    logic                      i_start = 1'b0;
    logic [(N+1)*PTR_W-1:0]    i_row_ptr = '0;
    logic                      i_nnz_valid = 1'b0;
    logic                      o_nnz_ready;
    logic [DATA_W-1:0]         i_val_a = '0;
    logic [DATA_W-1:0]         i_val_x = '0;
    logic                      o_busy, o_done;
    logic [N*ACC_W-1:0]        o_result;
    logic [N-1:0]              o_ovf;

    spmv_row_engine #(.N_ROWS(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .PTR_W(PTR_W)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_row_ptr(i_row_ptr),
        .i_nnz_valid(i_nnz_valid), .o_nnz_ready(o_nnz_ready), .i_val_a(i_val_a),
        .i_val_x(i_val_x), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
        .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    int errs = 0, checks = 0;
    int ptr_q[N+1];
    int av[256], xv[256];
    longint exp_acc[N];
    logic [N-1:0] exp_ovf;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Row-by-row CSR evaluation with a clamp after every add.
    task automatic model();
        for (int r = 0; r < N; r++) begin
            longint s = 0;
            exp_ovf[r] = 1'b0;
            for (int j = ptr_q[r]; j < ptr_q[r+1]; j++) begin
                s += longint'(av[j]) * longint'(xv[j]);
                if (s > AMAX) begin s = AMAX; exp_ovf[r] = 1'b1; end
                if (s < AMIN) begin s = AMIN; exp_ovf[r] = 1'b1; end
            end
            exp_acc[r] = s;
        end
    endtask

    task automatic chk_results(input string tag);
        model();
        for (int r = 0; r < N; r++)
            chk($sformatf("%s_acc%0d", tag, r),
                longint'($signed(o_result[r*ACC_W +: ACC_W])), exp_acc[r]);
        chk({tag, "_ovf"}, longint'(o_ovf), longint'(exp_ovf));
    endtask

    // vmode: 0 valid held, 1 pattern 1,0,0,1,0,1, 2 random. rst_at >= 0 resets on that accept.
    task automatic run_job(input string tag, input int vmode, input bit poke, input int rst_at);
        int np, idx, cyc, lat;
        bit v, acc;
        bit pat[6] = '{1, 0, 0, 1, 0, 1};
        np = ptr_q[N];
        for (int r = 0; r <= N; r++) i_row_ptr[r*PTR_W +: PTR_W] = PTR_W'(ptr_q[r]);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_row_ptr = {(N+1){PTR_W'($urandom)}};
        chk({tag, "_busy"}, o_busy, 1);
        idx = 0; cyc = 0;
        while (idx < np && cyc < 500) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[cyc % 6] : 1'($urandom_range(0, 1));
            i_nnz_valid = v;
            i_val_a = v ? DATA_W'(av[idx]) : DATA_W'($urandom);
            i_val_x = v ? DATA_W'(xv[idx]) : DATA_W'($urandom);
            i_start = poke && (cyc == 1);
            chk({tag, "_ready"}, o_nnz_ready, 1);
            if (rst_at == idx && v) i_rstn = 1'b0;
            acc = v;
            tick();
            cyc++;
            if (!i_rstn) begin
                i_nnz_valid = 1'b0;
                chk({tag, "_rst_busy"}, o_busy, 0);
                chk({tag, "_rst_ready"}, o_nnz_ready, 0);
                chk({tag, "_rst_res"}, longint'(o_result != '0), 0);
                chk({tag, "_rst_ovf"}, longint'(o_ovf), 0);
                i_rstn = 1'b1;
                lat = 0;
                for (int c = 0; c < 8; c++) begin
                    if (o_done) lat++;
                    tick();
                end
                chk({tag, "_rst_nodone"}, lat, 0);
                chk({tag, "_rst_idle"}, o_busy, 0);
                return;
            end
            if (acc) idx++;
        end
        i_nnz_valid = 1'b0;
        i_start = 1'b0;
        chk({tag, "_accepts"}, idx, np);
        lat = 0;
        while (!o_done && lat < 20) begin
            chk({tag, "_drain_ready"}, o_nnz_ready, 0);
            tick();
            lat++;
        end
        chk({tag, "_done_lat"}, lat, 3);
        if (poke) i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk({tag, "_done_pulse"}, o_done, 0);
        chk({tag, "_idle"}, o_busy, 0);
        chk_results(tag);
    endtask

    task automatic load_t1();
        ptr_q[0] = 0; ptr_q[1] = 2; ptr_q[2] = 2;
        for (int r = 3; r <= N; r++) ptr_q[r] = 3;
        av[0] = 2; xv[0] = 3; av[1] = 4; xv[1] = -1; av[2] = 5; xv[2] = 5;
    endtask

    int tot;

    initial begin
        repeat (3) tick();
        i_rstn = 1'b1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ready", o_nnz_ready, 0);
        chk("rst_ovf", longint'(o_ovf), 0);
        chk("rst_res", longint'(o_result != '0), 0);
        tick();

        load_t1();
        run_job("t1", 0, 0, -1);
        chk("t1_acc0", longint'($signed(o_result[0 +: ACC_W])), 2);
        chk("t1_acc2", longint'($signed(o_result[2*ACC_W +: ACC_W])), 25);

        run_job("t2", 1, 0, -1);

        for (int r = 0; r <= N; r++) ptr_q[r] = 0;
        run_job("t3", 0, 0, -1);

        ptr_q[0] = 0;
        for (int r = 1; r <= N; r++) ptr_q[r] = 3;
        for (int j = 0; j < 3; j++) begin av[j] = 32767; xv[j] = 32767; end
        run_job("t4", 0, 0, -1);
        chk("t4_sat", longint'($signed(o_result[0 +: ACC_W])), AMAX);
        chk("t4_ovf0", o_ovf[0], 1);
        repeat (2) tick();
        chk("t4_hold_ovf", o_ovf[0], 1);
        for (int r = 0; r <= N; r++) ptr_q[r] = 0;
        run_job("t4b", 0, 0, -1);
        chk("t4b_ovf0", o_ovf[0], 0);

        load_t1();
        run_job("t5", 0, 0, 1);
        run_job("t5b", 0, 0, -1);

        run_job("t6", 0, 1, -1);

        for (int n = 0; n < 12; n++) begin
            tot = $urandom_range(1, 60);
            ptr_q[0] = 0;
            for (int r = 1; r < N; r++) begin
                ptr_q[r] = ptr_q[r-1] + $urandom_range(0, 5);
                if (ptr_q[r] > tot) ptr_q[r] = tot;
            end
            ptr_q[N] = tot;
            for (int j = 0; j < tot; j++) begin
                case ($urandom_range(0, 3))
                    0: begin av[j] = -32768; xv[j] = ($urandom_range(0, 1) != 0) ? -32768 : 32767; end
                    1: begin av[j] = 32767; xv[j] = 32767; end
                    default: begin
                        av[j] = int'($signed(DATA_W'($urandom)));
                        xv[j] = int'($signed(DATA_W'($urandom)));
                    end
                endcase
            end
            run_job($sformatf("rnd%0d", n), 2, 1'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
